// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write/read port bundle for the 32x32 register file
interface register_file_if;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [4:0]  Read_register1;
    logic [4:0]  Read_register2;
    logic [31:0] Read_data1;
    logic [31:0] Read_data2;

    modport master (
        output RegWrite,
        output Write_register,
        output Write_data,
        output Read_register1,
        output Read_register2,
        input  Read_data1,
        input  Read_data2
    );

    modport slave (
        input  RegWrite,
        input  Write_register,
        input  Write_data,
        input  Read_register1,
        input  Read_register2,
        output Read_data1,
        output Read_data2
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two combinational read ports, one write port
module register_file (
    input  logic                   clk,
    input  logic                   reset,
    register_file_if.slave         bus
);
    logic [31:0] regs [0:31];

    // Reset seeds each register with its own index; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (bus.RegWrite && (bus.Write_register != 5'd0)) begin
            regs[bus.Write_register] <= bus.Write_data;
        end
    end

    // Address 0 is forced to zero so it is defined even before the first reset.
    always_comb begin
        bus.Read_data1 = (bus.Read_register1 == 5'd0) ? 32'd0 : regs[bus.Read_register1];
        bus.Read_data2 = (bus.Read_register2 == 5'd0) ? 32'd0 : regs[bus.Read_register2];
    end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized and directed self-checking bench for register_file
module tb_register_file;
    logic clk;
    logic reset;
    int   total;
    int   passed;
    int   failed;
    logic [31:0] model [0:31];

    register_file_if bus ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_rd1"}, bus.Read_data1, expect_rd(bus.Read_register1));
        check({tag, "_rd2"}, bus.Read_data2, expect_rd(bus.Read_register2));
    endtask

    task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        bus.Read_register1 = a1;
        bus.Read_register2 = a2;
        #1;
        check_both(tag);
    endtask

    // One rising edge; the model applies the reset/write rules to the inputs held across it.
    task automatic edge_step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = i;
        end else if (bus.RegWrite && bus.Write_register != 5'd0) begin
            model[bus.Write_register] = bus.Write_data;
        end
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        for (int i = 0; i < 32; i++) model[i] = 'x;
        reset              = 1'b1;
        bus.RegWrite       = 1'b0;
        bus.Write_register = 5'd0;
        bus.Write_data     = 32'd0;
        bus.Read_register1 = 5'd0;
        bus.Read_register2 = 5'd0;

        edge_step();
        edge_step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            read_pair("reset_val", 5'(i), 5'(31 - i));
            check("reset_abs", bus.Read_data1, 32'(i));
        end

        read_pair("r5_0", 5'd5, 5'd0);
        check("r5_abs", bus.Read_data1, 32'd5);
        check("r0_abs", bus.Read_data2, 32'd0);
        read_pair("r10_5", 5'd10, 5'd5);
        read_pair("r15_10", 5'd15, 5'd10);
        read_pair("r20_15", 5'd20, 5'd15);
        read_pair("same_addr", 5'd9, 5'd9);

        bus.RegWrite = 1'b1; bus.Write_register = 5'd7; bus.Write_data = 32'hDEAD_BEEF;
        read_pair("rdw_before", 5'd7, 5'd7);
        check("rdw_before_abs", bus.Read_data1, 32'd7);
        edge_step();
        check("rdw_after_abs", bus.Read_data1, 32'hDEAD_BEEF);
        check_both("rdw_after");

        bus.Write_register = 5'd0; bus.Write_data = 32'hFFFF_FFFF;
        edge_step();
        read_pair("wr_zero", 5'd0, 5'd0);
        check("wr_zero_abs", bus.Read_data1, 32'd0);

        bus.Write_register = 5'd20; bus.Write_data = 32'h1234_5678;
        edge_step();
        read_pair("w20", 5'd20, 5'd7);
        check("w20_abs", bus.Read_data1, 32'h1234_5678);

        // Reset rising between edges must not disturb contents.
        reset = 1'b1; bus.Write_data = 32'hAAAA_AAAA;
        #2;
        check("async_rst_20", bus.Read_data1, 32'h1234_5678);
        check("async_rst_7", bus.Read_data2, 32'hDEAD_BEEF);
        edge_step();
        reset = 1'b0; bus.RegWrite = 1'b0;
        read_pair("rst_prio", 5'd20, 5'd7);
        check("rst_prio_abs", bus.Read_data1, 32'd20);

        bus.Write_register = 5'd3; bus.Write_data = 32'h5555_5555;
        for (int i = 0; i < 4; i++) edge_step();
        read_pair("no_we", 5'd3, 5'd3);
        check("no_we_abs", bus.Read_data1, 32'd3);

        for (int n = 0; n < 300; n++) begin
            reset              = ($urandom_range(0, 39) == 0);
            bus.RegWrite       = $urandom_range(0, 1);
            bus.Write_register = 5'($urandom_range(0, 31));
            bus.Write_data     = $urandom;
            bus.Read_register1 = ($urandom_range(0, 1) == 1) ? bus.Write_register : 5'($urandom_range(0, 31));
            bus.Read_register2 = 5'($urandom_range(0, 31));
            #1;
            check_both("rand_pre");
            edge_step();
            check_both("rand_post");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits, address width at 5 bits, depth at 32 registers.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 RegWrite  input  1  write enable for the write port.
REQ-005 Write_register  input  5  write address.
REQ-006 Write_data  input  32  write data.
REQ-007 Read_register1  input  5  read address, port 1.
REQ-008 Read_register2  input  5  read address, port 2.
REQ-009 Read_data1  output  32  read data, port 1.
REQ-010 Read_data2  output  32  read data, port 2.

Function
REQ-011 The block SHALL hold 32 registers of 32 bits, indexed 0..31.
REQ-012 Read ports SHALL be combinational (zero latency): Read_dataN SHALL equal the current contents of register Read_registerN and SHALL update in the same time step as any address change.
REQ-013 The two read ports SHALL be fully independent; both may address the same register simultaneously and SHALL return identical data.
REQ-014 Register 0 SHALL read as 32'h0000_0000 at all times; writes to address 0 SHALL be ignored.
REQ-015 On a rising clk edge with reset=0 and RegWrite=1, register Write_register (if nonzero) SHALL be loaded with Write_data.
REQ-016 On a rising clk edge with reset=0 and RegWrite=0, no register SHALL change.
REQ-017 Read-during-write: a read of the register being written SHALL return the old value until the rising edge, and the new value immediately after it (no bypass).
REQ-018 Write_register and Write_data SHALL be ignored whenever RegWrite=0.
REQ-019 There SHALL be no X propagation from an unused write port: if RegWrite is 0 or unconnected-low, contents SHALL remain at their reset values indefinitely.

Reset
REQ-020 On a rising clk edge with reset=1, every register i (0..31) SHALL be loaded with the value i zero-extended to 32 bits (register 5 = 32'd5, register 31 = 32'd31).
REQ-021 Reset SHALL take priority over a simultaneous write; a write requested in a reset cycle SHALL be discarded.
REQ-022 Reset asserted mid-operation SHALL restore all registers to their reset values on the next rising edge, regardless of prior writes.
REQ-023 Reset SHALL NOT act asynchronously; register contents SHALL not change between clock edges when reset rises or falls.
REQ-024 Before the first reset edge, register contents other than register 0 are unspecified; read outputs SHALL be valid only after at least one reset edge.

Verification
REQ-025 Hold reset=1 for two clk edges, RegWrite=0, then reset=0; read addresses 5/0 -> Read_data1=5, Read_data2=0.
REQ-026 After reset, read 10/5, then 15/10, then 20/15 -> outputs 10/5, 15/10, 20/15, each valid in the same time step as the address change.
REQ-027 RegWrite=1, Write_register=7, Write_data=32'hDEAD_BEEF, Read_register1=7 -> Read_data1=7 before the edge, 32'hDEAD_BEEF after it.
REQ-028 RegWrite=1, Write_register=0, Write_data=32'hFFFF_FFFF -> Read_data1 at address 0 remains 0 after the edge.
REQ-029 Write register 20 with 32'h1234_5678, then assert reset=1 with RegWrite=1 writing 32'hAAAA_AAAA to register 20 -> after the edge register 20 reads 32'd20.
REQ-030 RegWrite=0 with Write_register=3, Write_data=32'h5555_5555 over several edges -> register 3 still reads 32'd3.
